write_resp_channel_dec: RTL and testbench

- AXI4 interconnect write-response (B) channel decoder.
- Takes the single arbitrated B response from the slave side and steers BVALID/BRESP to the master port whose ID is in Sel_Resp_ID.
- Steers the selected master's BREADY back to the slave side.
- A small clocked monitor counts handshakes per master and error responses, and flags B-channel stability violations.
- Sits between the write-response arbiter/mux and the master-facing S0x_AXI ports.

---
 rtl/write_resp_channel_dec_pkg.sv | 13 +
 rtl/write_resp_monitor.sv | 58 +++++
 rtl/write_resp_channel_dec.sv | 60 ++++++
 tb/tb_write_resp_channel_dec.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/write_resp_channel_dec_pkg.sv
// write_resp_channel_dec_pkg: shared BRESP encodings and master-index type
// for the write-response decoder.
package write_resp_channel_dec_pkg;
   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } bresp_e;
   localparam int NUM_MASTERS = 2;
   localparam int MASTER_ID_W = $clog2(NUM_MASTERS);
   typedef logic [MASTER_ID_W-1:0] master_idx_t;
endpackage

// File: rtl/write_resp_monitor.sv
// write_resp_monitor: B-channel handshake statistics and sticky
// valid/payload stability checker.
module write_resp_monitor
   import write_resp_channel_dec_pkg::*;
#(
   parameter int ID_W = 1,
   parameter int CW   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stat_clear,
   input  logic            valid,
   input  logic            ready,
   input  logic            in_range,
   input  logic [ID_W-1:0] id,
   input  logic [1:0]      resp,
   output logic [CW-1:0]   cnt_m0,
   output logic [CW-1:0]   cnt_m1,
   output logic [CW-1:0]   cnt_err,
   output logic            protocol_err
);
   logic            hs, hs_m0, hs_m1, hs_err, unstable;
   logic            pending_q;
   logic [ID_W-1:0] id_q;
   logic [1:0]      resp_q;
   assign hs       = valid & ready;
   assign hs_m0    = hs & in_range & (id == ID_W'(0));
   assign hs_m1    = hs & in_range & (id == ID_W'(1));
   assign hs_err   = hs & resp[1];
   // A stalled response must hold valid, ID and resp until accepted.
   assign unstable = pending_q & (!valid | (id != id_q) | (resp != resp_q));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q    <= 1'b0;
         id_q         <= '0;
         resp_q       <= RESP_OKAY;
         cnt_m0       <= '0;
         cnt_m1       <= '0;
         cnt_err      <= '0;
         protocol_err <= 1'b0;
      end else begin
         pending_q <= valid & !ready;
         id_q      <= id;
         resp_q    <= resp;
         if (stat_clear) begin
            cnt_m0       <= '0;
            cnt_m1       <= '0;
            cnt_err      <= '0;
            protocol_err <= 1'b0;
         end else begin
            if (hs_m0 && !(&cnt_m0)) cnt_m0 <= cnt_m0 + CW'(1);
            if (hs_m1 && !(&cnt_m1)) cnt_m1 <= cnt_m1 + CW'(1);
            if (hs_err && !(&cnt_err)) cnt_err <= cnt_err + CW'(1);
            if (unstable) protocol_err <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/write_resp_channel_dec.sv
// write_resp_channel_dec: steers the arbitrated AXI4 B response to the
// master selected by Sel_Resp_ID and returns that master's BREADY.
module write_resp_channel_dec
   import write_resp_channel_dec_pkg::*;
#(
   parameter int Num_Of_Masters  = 2,
   parameter int Master_ID_Width = $clog2(Num_Of_Masters),
   parameter int Count_Width     = 16
) (
   input  logic                       ACLK,
   input  logic                       ARESETN,
   input  logic [Master_ID_Width-1:0] Sel_Resp_ID,
   input  logic                       Sel_Valid,
   input  logic [1:0]                 Sel_Write_Resp,
   output logic                       Sel_Ready,
   output logic                       S00_AXI_bvalid,
   output logic                       S01_AXI_bvalid,
   output logic [1:0]                 S00_AXI_bresp,
   output logic [1:0]                 S01_AXI_bresp,
   input  logic                       S00_AXI_bready,
   input  logic                       S01_AXI_bready,
   input  logic                       Stat_Clear,
   output logic [Count_Width-1:0]     Resp_Count_M0,
   output logic [Count_Width-1:0]     Resp_Count_M1,
   output logic [Count_Width-1:0]     Err_Resp_Count,
   output logic                       Decode_Err,
   output logic                       Protocol_Err
);
   localparam logic [Master_ID_Width:0] ID_LIMIT = (Master_ID_Width+1)'(Num_Of_Masters);
   logic        in_range, sel0, sel1;
   master_idx_t sel_idx;
   assign in_range = {1'b0, Sel_Resp_ID} < ID_LIMIT;
   assign sel_idx  = master_idx_t'(Sel_Resp_ID);
   assign sel0     = in_range & (sel_idx == master_idx_t'(0));
   assign sel1     = in_range & (sel_idx == master_idx_t'(1));
   assign S00_AXI_bvalid = Sel_Valid & sel0;
   assign S01_AXI_bvalid = Sel_Valid & sel1;
   assign S00_AXI_bresp  = S00_AXI_bvalid ? Sel_Write_Resp : RESP_OKAY;
   assign S01_AXI_bresp  = S01_AXI_bvalid ? Sel_Write_Resp : RESP_OKAY;
   // Unknown IDs are sunk so the slave side never deadlocks.
   assign Sel_Ready  = sel0 ? S00_AXI_bready : sel1 ? S01_AXI_bready : 1'b1;
   assign Decode_Err = Sel_Valid & !in_range;
   write_resp_monitor #(
      .ID_W (Master_ID_Width),
      .CW   (Count_Width)
   ) u_monitor (
      .clk          (ACLK),
      .rst_n        (ARESETN),
      .stat_clear   (Stat_Clear),
      .valid        (Sel_Valid),
      .ready        (Sel_Ready),
      .in_range     (in_range),
      .id           (Sel_Resp_ID),
      .resp         (Sel_Write_Resp),
      .cnt_m0       (Resp_Count_M0),
      .cnt_m1       (Resp_Count_M1),
      .cnt_err      (Err_Resp_Count),
      .protocol_err (Protocol_Err)
   );
endmodule

// File: tb/tb_write_resp_channel_dec.sv
// tb_write_resp_channel_dec: table-driven routing vectors plus directed
// sequences for counting, saturation, stability and async reset.
module tb_write_resp_channel_dec;
   localparam int IDW = 2;
   localparam int CW  = 4;
   logic           clk = 1'b0;
   logic           rst_n;
   logic [IDW-1:0] id;
   logic           valid;
   logic [1:0]     resp;
   logic           ready;
   logic           v0, v1;
   logic [1:0]     b0, b1;
   logic           r0, r1;
   logic           clr;
   logic [CW-1:0]  m0, m1, ec;
   logic           derr, perr;
   int             n_chk = 0;
   int             n_fail = 0;
   typedef struct {
      logic           v;
      logic [IDW-1:0] id;
      logic [1:0]     rs;
      logic           r0, r1;
      logic           ev0, ev1;
      logic [1:0]     eb0, eb1;
      logic           erdy, ederr;
   } vec_t;
   vec_t vec [9];
   always #5 clk = ~clk;
   write_resp_channel_dec #(
      .Num_Of_Masters  (2),
      .Master_ID_Width (IDW),
      .Count_Width     (CW)
   ) dut (
      .ACLK           (clk),
      .ARESETN        (rst_n),
      .Sel_Resp_ID    (id),
      .Sel_Valid      (valid),
      .Sel_Write_Resp (resp),
      .Sel_Ready      (ready),
      .S00_AXI_bvalid (v0),
      .S01_AXI_bvalid (v1),
      .S00_AXI_bresp  (b0),
      .S01_AXI_bresp  (b1),
      .S00_AXI_bready (r0),
      .S01_AXI_bready (r1),
      .Stat_Clear     (clr),
      .Resp_Count_M0  (m0),
      .Resp_Count_M1  (m1),
      .Err_Resp_Count (ec),
      .Decode_Err     (derr),
      .Protocol_Err   (perr)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [IDW-1:0] i, input logic [1:0] rs,
                        input logic rd0, input logic rd1);
      valid = v; id = i; resp = rs; r0 = rd0; r1 = rd1;
   endtask
   initial begin
      vec[0] = '{1'b1, 2'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
      vec[1] = '{1'b1, 2'd1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0};
      vec[2] = '{1'b0, 2'd1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
      vec[3] = '{1'b1, 2'd0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0};
      vec[4] = '{1'b1, 2'd1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0};
      vec[5] = '{1'b0, 2'd0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
      vec[6] = '{1'b1, 2'd3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
      vec[7] = '{1'b1, 2'd2, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
      vec[8] = '{1'b0, 2'd3, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
      rst_n = 1'b0;
      clr   = 1'b0;
      drive(1'b0, 2'd0, 2'b00, 1'b0, 1'b0);
      #1;
      chk("reset_m0", m0, 0);
      chk("reset_m1", m1, 0);
      chk("reset_err_cnt", ec, 0);
      chk("reset_perr", perr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      clr   = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive(vec[i].v, vec[i].id, vec[i].rs, vec[i].r0, vec[i].r1);
         #1;
         chk($sformatf("v%0d_bvalid0", i), v0, vec[i].ev0);
         chk($sformatf("v%0d_bvalid1", i), v1, vec[i].ev1);
         chk($sformatf("v%0d_bresp0", i), b0, vec[i].eb0);
         chk($sformatf("v%0d_bresp1", i), b1, vec[i].eb1);
         chk($sformatf("v%0d_ready", i), ready, vec[i].erdy);
         chk($sformatf("v%0d_decode_err", i), derr, vec[i].ederr);
      end
      @(negedge clk);
      chk("clear_prio_m0", m0, 0);
      chk("clear_prio_m1", m1, 0);
      chk("clear_prio_err", ec, 0);
      chk("clear_prio_perr", perr, 0);
      clr = 1'b0;
      drive(1'b0, 2'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 2'd1, 2'b10, 1'b0, 1'b1);
      #1 chk("m1_hs_ready", ready, 1);
      @(negedge clk);
      drive(1'b0, 2'd1, 2'b10, 1'b0, 1'b1);
      chk("m1_hs_cnt_m1", m1, 1);
      chk("m1_hs_cnt_err", ec, 1);
      chk("m1_hs_cnt_m0", m0, 0);
      chk("m1_hs_perr", perr, 0);
      drive(1'b1, 2'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 2'd0, 2'b00, 1'b0, 1'b0);
      chk("stall_no_perr_yet", perr, 0);
      chk("stall_no_count", m0, 0);
      @(negedge clk);
      chk("drop_perr_set", perr, 1);
      @(negedge clk);
      chk("perr_sticky", perr, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clear_perr", perr, 0);
      chk("clear_m1", m1, 0);
      chk("clear_err_cnt", ec, 0);
      drive(1'b1, 2'd3, 2'b11, 1'b0, 1'b0);
      #1;
      chk("dec_ready", ready, 1);
      chk("dec_err", derr, 1);
      chk("dec_no_bvalid", {v0, v1}, 0);
      @(negedge clk);
      drive(1'b0, 2'd0, 2'b00, 1'b0, 1'b0);
      chk("dec_m0", m0, 0);
      chk("dec_m1", m1, 0);
      chk("dec_err_cnt", ec, 1);
      chk("dec_perr", perr, 0);
      drive(1'b1, 2'd0, 2'b00, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      chk("sat_m0", m0, 15);
      chk("sat_err_cnt", ec, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_m0", m0, 0);
      chk("async_rst_err_cnt", ec, 0);
      chk("rst_routing_bvalid0", v0, 1);
      chk("rst_routing_ready", ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 2'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      chk("post_rst_m0", m0, 0);
      chk("post_rst_perr", perr, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
